imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction-memory load port. Takes a byte stream from the debug UART receiver, packs each group of 4 bytes into a little-endian 32-bit word, and drives write_en/data/addr_wr of the IF-stage instruction memory.
- Addresses increment by 4 from 0 on each write.
- Load ends on a halt word or an error. load_busy stalls the CPU while a load is in progress.

Parameters:
- MEM_BYTES, 1024, instruction memory size in bytes; must be a multiple of 4.
- HALT_WORD, 32'hFFFFFFFF, terminator word; it is written to memory, then the load ends.
- BYTE_TIMEOUT, 100000, maximum clk cycles allowed between bytes while a load is active.

Ports:
- clk  in  1  system clock; everything happens on the rising edge.
- reset  in  1  synchronous, active-low reset.
- load_start  in  1  one-cycle request to begin a new program load.
- rx_data  in  8  byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in the same cycle.
- imem_write_en  out  1  write strobe to instruction memory.
- imem_data  out  32  word to write; byte 0 goes on [7:0].
- imem_addr_wr  out  32  byte address to write; always a multiple of 4.
- load_busy  out  1  high from load start until DONE or ERR; stalls the pipeline.
- load_done  out  1  sticky; set when HALT_WORD has been written.
- load_error  out  1  sticky error flag.
- err_code  out  2  00 none, 01 byte timeout, 10 memory overflow.
- word_count  out  9  number of words written in the current load.

Behaviour:
- Reset: clk and reset are the only clock and reset. Reset is synchronous, active-low: while reset is low at a clk rising edge, the block clears.
  - State goes to IDLE.
  - All outputs go to 0; internal byte counter, address and timer go to 0.
  - Reset asserted mid-load abandons the partial word with no write. Words already written stay in memory.
- States: IDLE, COLLECT, WRITE, DONE, ERR.
- IDLE: rx_valid is ignored. load_start=1 → COLLECT next cycle.
- Load start (from IDLE, DONE or ERR): clears addr, byte count, word_count, timer, load_done, load_error and err_code; load_busy=1 from the next cycle.
- COLLECT:
  - rx_valid=1 → rx_data goes into word[8*byte_cnt +: 8], byte_cnt increments, timer clears.
  - When the 4th byte is accepted (byte_cnt 3→0), go to WRITE next cycle.
  - load_start is ignored while in COLLECT or WRITE.
- Timer: counts every cycle in COLLECT with no rx_valid. Reaching BYTE_TIMEOUT-1 → ERR with err_code=01, including when zero bytes of the word have arrived.
- WRITE (exactly one cycle):
  - imem_write_en=1, imem_data=word, imem_addr_wr=addr.
  - Write latency is 1 cycle after the 4th byte's rx_valid.
  - Next cycle: addr += 4 and word_count += 1.
  - Next state:
    - word==HALT_WORD → DONE.
    - else if addr+4==MEM_BYTES → ERR with err_code=10, since memory is full with no halt.
    - else → COLLECT.
  - rx_valid arriving in the WRITE cycle is captured as byte 0 of the next word and is not dropped; the timer clears.
- imem_write_en is 0 in every state except WRITE. imem_data and imem_addr_wr hold their last values when write_en=0.
- DONE: load_done=1, load_busy=0. Holds until load_start or reset.
- ERR: load_error=1, load_busy=0, err_code held. Holds until load_start or reset.
- rx_valid is ignored in IDLE, DONE and ERR.
- Widths: addr is 32 bits internally compared against MEM_BYTES, so there is no wrap-around.
- word_count saturation is impossible because the overflow check caps it at MEM_BYTES/4 = 256.

Decomposition:
- Shared package imem_loader_pkg:
  - state enum with encodings IDLE=0, COLLECT=1, WRITE=2, DONE=3, ERR=4;
  - err_code constants ERR_NONE, ERR_TIMEOUT, ERR_OVERFLOW;
  - default HALT_WORD.
- One sub-module, byte_packer: byte counter plus 32-bit shift/assemble register, with a word_ready output. The FSM, timer and address counter stay in the top module.

Test Plan:
- Reset low for 2 cycles, then high → all outputs 0 and state IDLE; rx_valid bytes sent in IDLE produce no write.
- load_start, then bytes 0x13,0x00,0x00,0x20 → one write of imem_data=0x20000013 at imem_addr_wr=0 one cycle after the 4th byte; word_count=1; load_busy=1.
- Three words, then FF,FF,FF,FF → writes at 0, 4, 8, 12; the last is 0xFFFFFFFF; then load_done=1, load_busy=0, word_count=4.
- load_start, 2 bytes, then silence for BYTE_TIMEOUT cycles → load_error=1, err_code=01, no write issued; a subsequent load_start clears the error and a clean load succeeds.
- 256 non-halt words → 256 writes ending at addr 1020, then err_code=10; no write to address 1024.
- Reset low mid-word after 3 bytes → no write, outputs 0; a new load restarts at address 0. Separately: a byte on rx_valid in the WRITE cycle becomes byte 0 of the next word.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The state encoding is fixed so it can be compared against debug traces.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        DONE    = 3'd3,
        ERR     = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;

    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/imem_loader_if.sv
// Bundle of the loader's control, UART byte stream and instruction-memory write port.
// The master modport is the loader itself; slave is whoever drives the stream and observes the writes.
interface imem_loader_if;
    logic        load_start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        imem_write_en;
    logic [31:0] imem_data;
    logic [31:0] imem_addr_wr;
    logic        load_busy;
    logic        load_done;
    logic        load_error;
    logic [1:0]  err_code;
    logic [8:0]  word_count;

    modport master (
        input  load_start, rx_data, rx_valid,
        output imem_write_en, imem_data, imem_addr_wr,
        output load_busy, load_done, load_error, err_code, word_count
    );

    modport slave (
        output load_start, rx_data, rx_valid,
        input  imem_write_en, imem_data, imem_addr_wr,
        input  load_busy, load_done, load_error, err_code, word_count
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs four accepted bytes into a little-endian word. Only bytes 0..2 are stored;
// the completed word is presented combinationally with the fourth byte in the same cycle.
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [1:0]  byte_cnt;
    logic [23:0] partial;

    assign word_ready = byte_valid && (byte_cnt == 2'd3);
    assign word       = {byte_data, partial};

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            byte_cnt <= 2'd0;
            partial  <= 24'd0;
        end else if (byte_valid) begin
            // The counter wraps 3 -> 0, so the next byte starts a fresh word.
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
                2'd0:    partial[7:0]   <= byte_data;
                2'd1:    partial[15:8]  <= byte_data;
                2'd2:    partial[23:16] <= byte_data;
                default: partial        <= partial;
            endcase
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Writer side of the instruction-memory load port: UART bytes in, aligned 32-bit
// memory writes out, with halt-word termination, byte timeout and overflow detection.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          MEM_BYTES    = 1024,
    parameter logic [31:0] HALT_WORD    = DEFAULT_HALT_WORD,
    parameter int          BYTE_TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              reset,
    imem_loader_if.master     bus
);

    localparam int                 TIMER_W   = $clog2(BYTE_TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(BYTE_TIMEOUT - 1);
    localparam logic [31:0]        MEM_END   = 32'(MEM_BYTES);

    state_t             state;
    state_t             state_next;
    logic [TIMER_W-1:0] timer;
    logic [31:0]        addr;
    logic [31:0]        write_data;
    logic [31:0]        write_addr;
    logic               write_en;
    logic [1:0]         err_code;
    logic [8:0]         word_count;
    logic               load_go;
    logic               accept;
    logic [31:0]        packed_word;
    logic               word_ready;

    assign load_go = bus.load_start && (state == IDLE || state == DONE || state == ERR);
    assign accept  = bus.rx_valid && (state == COLLECT || state == WRITE);

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (load_go),
        .byte_valid (accept),
        .byte_data  (bus.rx_data),
        .word       (packed_word),
        .word_ready (word_ready)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (bus.load_start) state_next = COLLECT;
            end
            COLLECT: begin
                if (bus.rx_valid) begin
                    if (word_ready) state_next = WRITE;
                end else if (timer == TIMER_MAX) begin
                    state_next = ERR;
                end
            end
            WRITE: begin
                // A halt word in the last slot still counts as a clean finish.
                if (write_data == HALT_WORD)         state_next = DONE;
                else if (addr + 32'd4 == MEM_END)    state_next = ERR;
                else                                 state_next = COLLECT;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            write_en   <= 1'b0;
            write_data <= 32'd0;
            write_addr <= 32'd0;
            addr       <= 32'd0;
            word_count <= 9'd0;
            timer      <= '0;
            err_code   <= ERR_NONE;
        end else begin
            write_en <= (state_next == WRITE);
            if (load_go) begin
                addr       <= 32'd0;
                word_count <= 9'd0;
                timer      <= '0;
                err_code   <= ERR_NONE;
            end else begin
                if (state == COLLECT && word_ready) begin
                    write_data <= packed_word;
                    write_addr <= addr;
                end
                if (state == WRITE) begin
                    addr       <= addr + 32'd4;
                    word_count <= word_count + 9'd1;
                end
                if (accept || state == WRITE) begin
                    timer <= '0;
                end else if (state == COLLECT && timer != TIMER_MAX) begin
                    timer <= timer + 1'b1;
                end
                if (state == COLLECT && state_next == ERR) err_code <= ERR_TIMEOUT;
                if (state == WRITE && state_next == ERR)   err_code <= ERR_OVERFLOW;
            end
        end
    end

    assign bus.imem_write_en = write_en;
    assign bus.imem_data     = write_data;
    assign bus.imem_addr_wr  = write_addr;
    assign bus.load_busy     = (state == COLLECT) || (state == WRITE);
    assign bus.load_done     = (state == DONE);
    assign bus.load_error    = (state == ERR);
    assign bus.err_code      = err_code;
    assign bus.word_count    = word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: every load's byte stream is recorded and
// replayed through a word-level model to predict the writes and the final status.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int          TO    = 40;
    localparam int          MEMB  = 1024;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if bus ();

    imem_loader #(
        .MEM_BYTES    (MEMB),
        .HALT_WORD    (HALT),
        .BYTE_TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic [7:0]  stream[$];

    always @(negedge clk) begin
        if (bus.imem_write_en === 1'b1) begin
            obs_addr.push_back(bus.imem_addr_wr);
            obs_data.push_back(bus.imem_data);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs starting at a falling edge; returns at the next falling edge.
    task automatic applyStimulus(input logic start, input logic valid, input logic [7:0] data);
        bus.load_start = start;
        bus.rx_valid   = valid;
        bus.rx_data    = data;
        @(negedge clk);
        bus.load_start = 1'b0;
        bus.rx_valid   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic start_load();
        obs_addr.delete();
        obs_data.delete();
        stream.delete();
        applyStimulus(1'b1, 1'b0, 8'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        stream.push_back(b);
        applyStimulus(1'b0, 1'b1, b);
        idle(int'($urandom_range(gap_max, 0)));
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap_max);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT) w = 32'h0000_0013;
        return w;
    endfunction

    // Model: group the recorded stream into little-endian words; the load stops
    // after a halt word, or after the word that fills the memory.
    task automatic check_load(input string tag);
        logic [31:0] exp_addr[$];
        logic [31:0] exp_data[$];
        logic        halted;
        logic        overflow;
        int          n;
        halted   = 1'b0;
        overflow = 1'b0;
        for (int i = 0; i < stream.size() / 4; i++) begin
            logic [31:0] w;
            w = {stream[4*i+3], stream[4*i+2], stream[4*i+1], stream[4*i]};
            exp_addr.push_back(32'(4 * i));
            exp_data.push_back(w);
            if (w == HALT) begin
                halted = 1'b1;
                break;
            end
            if (4 * (i + 1) == MEMB) begin
                overflow = 1'b1;
                break;
            end
        end
        checkOutput({tag, "_nwrites"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
        n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), obs_addr[i], exp_addr[i]);
            checkOutput($sformatf("%s_data%0d", tag, i), obs_data[i], exp_data[i]);
        end
        checkOutput({tag, "_done"},  32'(bus.load_done),  32'(halted));
        checkOutput({tag, "_error"}, 32'(bus.load_error), 32'(overflow));
        checkOutput({tag, "_code"},  32'(bus.err_code),   overflow ? 32'd2 : 32'd0);
        checkOutput({tag, "_busy"},  32'(bus.load_busy),  32'(!(halted || overflow)));
        checkOutput({tag, "_wcount"}, 32'(bus.word_count), 32'(exp_addr.size()));
    endtask

    task automatic check_idle_outputs(input string tag);
        checkOutput({tag, "_we"},     32'(bus.imem_write_en), 32'd0);
        checkOutput({tag, "_data"},   bus.imem_data,          32'd0);
        checkOutput({tag, "_addr"},   bus.imem_addr_wr,       32'd0);
        checkOutput({tag, "_busy"},   32'(bus.load_busy),     32'd0);
        checkOutput({tag, "_done"},   32'(bus.load_done),     32'd0);
        checkOutput({tag, "_error"},  32'(bus.load_error),    32'd0);
        checkOutput({tag, "_code"},   32'(bus.err_code),      32'd0);
        checkOutput({tag, "_wcount"}, 32'(bus.word_count),    32'd0);
    endtask

    initial begin
        bus.load_start = 1'b0;
        bus.rx_valid   = 1'b0;
        bus.rx_data    = 8'd0;
        reset          = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs("rst");
        reset = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'($urandom));
        idle(2);
        checkOutput("idle_nwrites", 32'(obs_addr.size()), 32'd0);
        checkOutput("idle_busy", 32'(bus.load_busy), 32'd0);

        // First word latency and address, then a short program ending in halt.
        start_load();
        checkOutput("dir_busy0", 32'(bus.load_busy), 32'd1);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h20, 0);
        checkOutput("dir_we", 32'(bus.imem_write_en), 32'd1);
        checkOutput("dir_data", bus.imem_data, 32'h2000_0013);
        checkOutput("dir_addr", bus.imem_addr_wr, 32'd0);
        idle(1);
        checkOutput("dir_we_low", 32'(bus.imem_write_en), 32'd0);
        checkOutput("dir_wcount1", 32'(bus.word_count), 32'd1);
        checkOutput("dir_busy1", 32'(bus.load_busy), 32'd1);
        send_word(rand_word(), 2);
        send_word(rand_word(), 2);
        send_word(HALT, 2);
        idle(3);
        check_load("dir");

        // Byte timeout mid-word, then recovery with a clean load.
        start_load();
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        idle(TO - 10);
        checkOutput("to_early_error", 32'(bus.load_error), 32'd0);
        checkOutput("to_early_busy", 32'(bus.load_busy), 32'd1);
        idle(15);
        checkOutput("to_error", 32'(bus.load_error), 32'd1);
        checkOutput("to_code", 32'(bus.err_code), 32'd1);
        checkOutput("to_busy", 32'(bus.load_busy), 32'd0);
        checkOutput("to_nwrites", 32'(obs_addr.size()), 32'd0);
        start_load();
        checkOutput("rec_error", 32'(bus.load_error), 32'd0);
        checkOutput("rec_code", 32'(bus.err_code), 32'd0);
        checkOutput("rec_busy", 32'(bus.load_busy), 32'd1);
        for (int i = 0; i < 3; i++) send_word(rand_word(), 3);
        send_word(HALT, 3);
        idle(3);
        check_load("rec");

        // Fill memory without a halt word.
        start_load();
        for (int i = 0; i < MEMB / 4; i++) send_word(rand_word(), 0);
        idle(3);
        check_load("ovf");
        checkOutput("ovf_last_addr",
                    (obs_addr.size() > 0) ? obs_addr[obs_addr.size() - 1] : 32'hDEAD_BEEF,
                    32'(MEMB - 4));
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'($urandom));
        idle(2);
        checkOutput("ovf_ignored", 32'(obs_addr.size()), 32'(MEMB / 4));
        checkOutput("ovf_code_held", 32'(bus.err_code), 32'd2);

        // Reset in the middle of a word discards it.
        start_load();
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        idle(1);
        check_idle_outputs("midrst");
        checkOutput("midrst_nwrites", 32'(obs_addr.size()), 32'd0);
        start_load();
        send_word(rand_word(), 1);
        send_word(HALT, 1);
        idle(3);
        check_load("after_rst");

        // Back-to-back bytes: the fifth byte lands in the write cycle.
        start_load();
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0);
        send_word(HALT, 0);
        idle(3);
        check_load("wr_cycle");

        for (int r = 0; r < 4; r++) begin
            int n;
            n = int'($urandom_range(6, 1));
            start_load();
            for (int i = 0; i < n; i++) send_word(rand_word(), 3);
            send_word(HALT, 3);
            idle(3);
            check_load($sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
